// File: rtl/pb_assist_ctrl.sv
// ============================================================================
//  Module  : pb_assist_ctrl (with helper pb_assist_dbnc)
//  Brief   : Push-button assist-level controller for the e-bike. The raw mode
//            button is synchronised and debounced. A short press steps the
//            level with wrap, and a long press forces assist off. The block
//            drives the current level and a torque-scale code.
//  Options : PB_DOWN_BTN_EN - adds a debounced down button that steps the
//            level down and saturates at 0.
//  Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

// Two-flop synchroniser followed by a hold-time debouncer. The module exports
// the debounced level and its one-cycle-delayed copy so the parent can detect
// edges.
module pb_assist_dbnc #(
    parameter int unsigned DBNC_CYC = 50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw_i,
    output logic stb_o,
    output logic stb_prev_o
);
    localparam int unsigned c_dcnt_w = (DBNC_CYC > 1) ? $clog2(DBNC_CYC) : 1;
    localparam logic [c_dcnt_w-1:0] c_dbnc_last = c_dcnt_w'(DBNC_CYC - 1);

    logic                meta_q;
    logic                sync_q;
    logic                stb_q;
    logic                stb_prev_q;
    logic [c_dcnt_w-1:0] dcnt_q;

    // Synchronise the raw input, then accept a new value only after it has been stable for DBNC_CYC cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q     <= 1'b0;
            sync_q     <= 1'b0;
            stb_q      <= 1'b0;
            stb_prev_q <= 1'b0;
            dcnt_q     <= '0;
        end else begin
            meta_q     <= btn_raw_i;
            sync_q     <= meta_q;
            stb_prev_q <= stb_q;
            if (sync_q == stb_q) begin
                dcnt_q <= '0;
            end else if (dcnt_q == c_dbnc_last) begin
                stb_q  <= sync_q;
                dcnt_q <= '0;
            end else begin
                dcnt_q <= dcnt_q + 1'b1;
            end
        end
    end

    assign stb_o      = stb_q;
    assign stb_prev_o = stb_prev_q;
endmodule

module pb_assist_ctrl #(
    parameter  int unsigned NUM_LVL  = 4,
    parameter  int unsigned DBNC_CYC = 50000,
    parameter  int unsigned LONG_CYC = 6000000,
    parameter  int unsigned RST_LVL  = 2,
    localparam int unsigned LVL_W    = $clog2(NUM_LVL)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             btn_raw,
`ifdef PB_DOWN_BTN_EN
    input  logic             btn_dn_raw,
`endif
    output logic [LVL_W-1:0] setting,
    output logic [LVL_W:0]   scale,
    output logic             lvl_chg
);
    localparam int unsigned      c_hcnt_w   = $clog2(LONG_CYC + 1);
    localparam logic [c_hcnt_w-1:0] c_long    = c_hcnt_w'(LONG_CYC);
    localparam logic [c_hcnt_w-1:0] c_long_m1 = c_hcnt_w'(LONG_CYC - 1);
    localparam logic [LVL_W-1:0] c_top_lvl  = LVL_W'(NUM_LVL - 1);
    localparam logic [LVL_W-1:0] c_rst_lvl  = LVL_W'(RST_LVL);

    // Reject illegal parameter sets at elaboration.
    if (NUM_LVL < 2) begin : g_chk_num_lvl
        $error("pb_assist_ctrl: NUM_LVL must be >= 2");
    end
    if (RST_LVL >= NUM_LVL) begin : g_chk_rst_lvl
        $error("pb_assist_ctrl: RST_LVL must be < NUM_LVL");
    end
    if (DBNC_CYC < 1) begin : g_chk_dbnc
        $error("pb_assist_ctrl: DBNC_CYC must be >= 1");
    end
    if (LONG_CYC < 2) begin : g_chk_long
        $error("pb_assist_ctrl: LONG_CYC must be >= 2");
    end

    logic                up_stb;
    logic                up_stb_prev;
    logic                up_rise;
    logic                up_fall;
    logic                dn_fall;
    logic                long_hit;
    logic                up_step;

    logic [LVL_W-1:0]    setting_q;
    logic [LVL_W-1:0]    setting_d;
    logic                lvl_chg_q;
    logic                lvl_chg_d;
    logic [c_hcnt_w-1:0] hcnt_q;
    logic                long_done_q;

    pb_assist_dbnc #(
        .DBNC_CYC (DBNC_CYC)
    ) u_dbnc_up (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_raw_i  (btn_raw),
        .stb_o      (up_stb),
        .stb_prev_o (up_stb_prev)
    );

`ifdef PB_DOWN_BTN_EN
    logic dn_stb;
    logic dn_stb_prev;

    pb_assist_dbnc #(
        .DBNC_CYC (DBNC_CYC)
    ) u_dbnc_dn (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_raw_i  (btn_dn_raw),
        .stb_o      (dn_stb),
        .stb_prev_o (dn_stb_prev)
    );

    assign dn_fall = dn_stb_prev & ~dn_stb;
`else
    assign dn_fall = 1'b0;
`endif

    assign up_rise  = up_stb & ~up_stb_prev;
    assign up_fall  = up_stb_prev & ~up_stb;
    // The hold counter reaches LONG_CYC on this cycle's edge. The rise cycle is excluded because it restarts the count.
    assign long_hit = up_stb & ~up_rise & (hcnt_q == c_long_m1);
    // A release after a long press never steps the level.
    assign up_step  = up_fall & ~long_done_q;

    // Select the next level. Long-press-off takes priority, and simultaneous up/down releases cancel.
    always_comb begin
        setting_d = setting_q;
        lvl_chg_d = 1'b0;
        if (long_hit) begin
            setting_d = '0;
            lvl_chg_d = (setting_q != '0);
        end else if (up_step && dn_fall) begin
            setting_d = setting_q;
        end else if (up_step) begin
            setting_d = (setting_q == c_top_lvl) ? '0 : setting_q + 1'b1;
            lvl_chg_d = 1'b1;
        end else if (dn_fall) begin
            if (setting_q != '0) begin
                setting_d = setting_q - 1'b1;
                lvl_chg_d = 1'b1;
            end
        end
    end

    // Register the level and change pulse, and track how long the up button has been held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            setting_q   <= c_rst_lvl;
            lvl_chg_q   <= 1'b0;
            hcnt_q      <= '0;
            long_done_q <= 1'b0;
        end else begin
            setting_q <= setting_d;
            lvl_chg_q <= lvl_chg_d;
            if (up_rise) begin
                hcnt_q      <= '0;
                long_done_q <= 1'b0;
            end else if (up_stb && (hcnt_q != c_long)) begin
                hcnt_q <= hcnt_q + 1'b1;
                if (hcnt_q == c_long_m1) begin
                    long_done_q <= 1'b1;
                end
            end
        end
    end

    // Torque scale is 2*setting+1 for any non-zero level, and 0 when assist is off.
    always_comb begin
        scale = '0;
        if (setting_q != '0) begin
            scale = {setting_q, 1'b1};
        end
    end

    assign setting = setting_q;
    assign lvl_chg = lvl_chg_q;
endmodule

`default_nettype wire

// File: tb/tb_pb_assist_ctrl.sv
// ============================================================================
//  Module  : tb_pb_assist_ctrl
//  Brief   : Directed self-checking bench for pb_assist_ctrl using
//            NUM_LVL=4, DBNC_CYC=4, LONG_CYC=16 and RST_LVL=2.
//  Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pb_assist_ctrl;
    logic       clk;
    logic       rst_n;
    logic       btn_raw;
    logic       btn_dn_raw;
    logic [1:0] setting;
    logic [2:0] scale;
    logic       lvl_chg;

    int n_cmp  = 0;
    int n_fail = 0;
    int chg_cnt = 0;
    int c0;

    pb_assist_ctrl #(
        .NUM_LVL  (4),
        .DBNC_CYC (4),
        .LONG_CYC (16),
        .RST_LVL  (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_raw    (btn_raw),
`ifdef PB_DOWN_BTN_EN
        .btn_dn_raw (btn_dn_raw),
`endif
        .setting    (setting),
        .scale      (scale),
        .lvl_chg    (lvl_chg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count every lvl_chg pulse, sampled on the inactive edge.
    always @(negedge clk) begin
        if (lvl_chg === 1'b1) chg_cnt++;
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Short press: held for 8 cycles. The change shows up 7 sampled cycles after release.
    task automatic short_press(input string tag, input int exp_set, input int exp_scale);
        btn_raw = 1'b1;
        cyc(8);
        btn_raw = 1'b0;
        cyc(6);
        chk({tag, "_chg_early"}, lvl_chg, 0);
        cyc(1);
        chk({tag, "_set"}, setting, exp_set);
        chk({tag, "_scale"}, scale, exp_scale);
        chk({tag, "_chg"}, lvl_chg, 1);
        cyc(1);
        chk({tag, "_chg_1cyc"}, lvl_chg, 0);
        cyc(3);
    endtask

    int exp_set[4]   = '{3, 0, 1, 2};
    int exp_scale[4] = '{7, 0, 3, 5};

    initial begin
        rst_n      = 1'b0;
        btn_raw    = 1'b0;
        btn_dn_raw = 1'b0;
        cyc(3);
        chk("rst_setting", setting, 2);
        chk("rst_scale", scale, 5);
        chk("rst_chg", lvl_chg, 0);
        rst_n = 1'b1;
        cyc(2);

        // Reset is applied while the button is held. The level must not step until a later release.
        btn_raw = 1'b1;
        cyc(10);
        rst_n = 1'b0;
        cyc(3);
        chk("midrst_setting", setting, 2);
        chk("midrst_chg", lvl_chg, 0);
        rst_n = 1'b1;
        c0 = chg_cnt;
        cyc(14);
        chk("midrst_held_setting", setting, 2);
        chk("midrst_held_chgcnt", chg_cnt - c0, 0);
        btn_raw = 1'b0;
        cyc(6);
        chk("midrst_rel_early", setting, 2);
        cyc(1);
        chk("midrst_rel_setting", setting, 3);
        chk("midrst_rel_chg", lvl_chg, 1);
        cyc(3);

        // Four short presses starting from 2. The level wraps back to 0 after 3.
        rst_n = 1'b0;
        cyc(2);
        rst_n = 1'b1;
        cyc(2);
        chk("rst2_setting", setting, 2);
        c0 = chg_cnt;
        for (int i = 0; i < 4; i++) begin
            short_press($sformatf("short%0d", i), exp_set[i], exp_scale[i]);
        end
        chk("short_chgcnt", chg_cnt - c0, 4);

        // Glitches of 3 cycles are too short to pass the debouncer.
        c0 = chg_cnt;
        repeat (10) begin
            btn_raw = 1'b1;
            cyc(3);
            btn_raw = 1'b0;
            cyc(5);
        end
        cyc(8);
        chk("glitch_setting", setting, 2);
        chk("glitch_chgcnt", chg_cnt - c0, 0);

        // Long press from 3: the level goes to 0 when the hold count reaches 16.
        short_press("pre_long", 3, 7);
        c0 = chg_cnt;
        btn_raw = 1'b1;
        cyc(22);
        chk("long_pre_setting", setting, 3);
        cyc(1);
        chk("long_setting", setting, 0);
        chk("long_chg", lvl_chg, 1);
        cyc(20);
        btn_raw = 1'b0;
        cyc(12);
        chk("long_rel_setting", setting, 0);
        chk("long_chgcnt", chg_cnt - c0, 1);

        // A second long press while already at 0 must not pulse lvl_chg.
        c0 = chg_cnt;
        btn_raw = 1'b1;
        cyc(23);
        chk("long0_setting", setting, 0);
        chk("long0_chg", lvl_chg, 0);
        cyc(20);
        btn_raw = 1'b0;
        cyc(12);
        chk("long0_rel_setting", setting, 0);
        chk("long0_chgcnt", chg_cnt - c0, 0);

        // Bouncy press: 6 cycles of toggling, then held steady. Expect exactly one step.
        c0 = chg_cnt;
        for (int i = 0; i < 6; i++) begin
            btn_raw = ((i % 2) == 0);
            cyc(1);
        end
        btn_raw = 1'b1;
        cyc(10);
        btn_raw = 1'b0;
        cyc(12);
        chk("bouncy_setting", setting, 1);
        chk("bouncy_chgcnt", chg_cnt - c0, 1);

`ifdef PB_DOWN_BTN_EN
        // Down button steps the level down and saturates at 0.
        btn_dn_raw = 1'b1;
        cyc(8);
        btn_dn_raw = 1'b0;
        cyc(7);
        chk("dn1_setting", setting, 0);
        chk("dn1_chg", lvl_chg, 1);
        cyc(3);
        btn_dn_raw = 1'b1;
        cyc(8);
        btn_dn_raw = 1'b0;
        cyc(7);
        chk("dn2_setting", setting, 0);
        chk("dn2_chg", lvl_chg, 0);
        cyc(3);
        // Up and down released together: the two cancel.
        btn_raw    = 1'b1;
        btn_dn_raw = 1'b1;
        cyc(8);
        btn_raw    = 1'b0;
        btn_dn_raw = 1'b0;
        cyc(7);
        chk("both_setting", setting, 0);
        chk("both_chg", lvl_chg, 0);
        cyc(3);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

`default_nettype wire
